// File: rtl/MCLA_4_c_c0.sv
// 4-bit carry-lookahead slice: s = a + b + c0, with s[4] the carry out.
module MCLA_4_c_c0 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c0_i,
    output logic [4:0] s_o
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a_i & b_i;
        p    = a_i ^ b_i;
        c[0] = c0_i;
        c[1] = g[0] | (p[0] & c0_i);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0_i);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0_i);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (&p & c0_i);
        s_o  = {c[4], p ^ c[3:0]};
    end
endmodule

// File: rtl/mcla_nibble_seq.sv
// Nibble-serial WIDTH-bit adder: a single 4-bit CLA slice is reused for NIB cycles,
// with the slice carry held in a register between nibbles.
module mcla_nibble_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH:0]   sum_o,
    output logic             busy_o
);
    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned CntW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NIB - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [4:0]       slice_s;
    logic             accept;
    logic             last_nib;

    assign accept   = in_valid_i && in_ready_o;
    assign last_nib = (cnt_q == LastCnt);

    // Operand registers shift right each RUN cycle, so the slice always sees bits [3:0].
    MCLA_4_c_c0 u_slice (
        .a_i  (a_q[3:0]),
        .b_i  (b_q[3:0]),
        .c0_i (carry_q),
        .s_o  (slice_s)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StRun;
            StRun:   if (last_nib) state_d = StDone;
            StDone:  if (out_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // in_ready is gated by rst so nothing is offered while reset is held.
    always_comb begin
        in_ready_o  = (state_q == StIdle) && !rst_i;
        out_valid_o = (state_q == StDone);
        busy_o      = (state_q != StIdle);
        sum_o       = sum_q;
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        if (accept) begin
            a_d     = a_i;
            b_d     = b_i;
            carry_d = cin_i;
            cnt_d   = '0;
        end else if (state_q == StRun) begin
            a_d     = a_q >> 4;
            b_d     = b_q >> 4;
            carry_d = slice_s[4];
            for (int unsigned i = 0; i < NIB; i++) begin
                if (cnt_q == CntW'(i)) sum_d[4*i +: 4] = slice_s[3:0];
            end
            if (last_nib) begin
                sum_d[WIDTH] = slice_s[4];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
        end
    end
endmodule

// File: tb/tb_mcla_nibble_seq.sv
// Bench for mcla_nibble_seq at WIDTH 4, 16 and 32 against a cycle-level transaction model.
module tb_mcla_nibble_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv4, ir4, ov4, or4, bz4, ci4;
    logic [3:0]  a4, b4;
    logic [4:0]  s4;
    logic        iv16, ir16, ov16, or16, bz16, ci16;
    logic [15:0] a16, b16;
    logic [16:0] s16;
    logic        iv32, ir32, ov32, or32, bz32, ci32;
    logic [31:0] a32, b32;
    logic [32:0] s32;

    mcla_nibble_seq #(.WIDTH(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv4), .in_ready_o(ir4), .a_i(a4), .b_i(b4),
        .cin_i(ci4), .out_valid_o(ov4), .out_ready_i(or4), .sum_o(s4), .busy_o(bz4)
    );
    mcla_nibble_seq #(.WIDTH(16)) u_dut16 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv16), .in_ready_o(ir16), .a_i(a16), .b_i(b16),
        .cin_i(ci16), .out_valid_o(ov16), .out_ready_i(or16), .sum_o(s16), .busy_o(bz16)
    );
    mcla_nibble_seq #(.WIDTH(32)) u_dut32 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv32), .in_ready_o(ir32), .a_i(a32), .b_i(b32),
        .cin_i(ci32), .out_valid_o(ov32), .out_ready_i(or32), .sum_o(s32), .busy_o(bz32)
    );

    // Per-instance views: 0 = WIDTH 4, 1 = WIDTH 16, 2 = WIDTH 32.
    logic [31:0] a_v [3];
    logic [31:0] b_v [3];
    logic [32:0] s_v [3];
    logic ci_v [3];
    logic iv_v [3];
    logic or_v [3];
    logic ov_v [3];
    logic ir_v [3];
    logic bz_v [3];
    assign a_v[0] = 32'(a4);   assign a_v[1] = 32'(a16);  assign a_v[2] = a32;
    assign b_v[0] = 32'(b4);   assign b_v[1] = 32'(b16);  assign b_v[2] = b32;
    assign s_v[0] = 33'(s4);   assign s_v[1] = 33'(s16);  assign s_v[2] = s32;
    assign ci_v[0] = ci4;      assign ci_v[1] = ci16;     assign ci_v[2] = ci32;
    assign iv_v[0] = iv4;      assign iv_v[1] = iv16;     assign iv_v[2] = iv32;
    assign or_v[0] = or4;      assign or_v[1] = or16;     assign or_v[2] = or32;
    assign ov_v[0] = ov4;      assign ov_v[1] = ov16;     assign ov_v[2] = ov32;
    assign ir_v[0] = ir4;      assign ir_v[1] = ir16;     assign ir_v[2] = ir32;
    assign bz_v[0] = bz4;      assign bz_v[1] = bz16;     assign bz_v[2] = bz32;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    // Model: one outstanding transaction per instance, result due NIB+1 cycles after accept.
    bit          m_busy [3] = '{0, 0, 0};
    logic [32:0] m_sum  [3];
    int          m_done [3] = '{0, 0, 0};
    int          m_acc  [3] = '{0, 0, 0};
    int          m_res  [3] = '{0, 0, 0};
    int          dut_res[3] = '{0, 0, 0};

    function automatic int nib_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 4 : 8);
    endfunction

    task automatic check(input string name, input int k, input logic [32:0] got,
                         input logic [32:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s[inst %0d] cycle %0d: got 0x%0h expected 0x%0h",
                     name, k, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_busy[k] <= 1'b0;
            end else if (!m_busy[k]) begin
                if (iv_v[k]) begin
                    m_busy[k] <= 1'b1;
                    m_sum[k]  <= {1'b0, a_v[k]} + {1'b0, b_v[k]} + 33'(ci_v[k]);
                    m_done[k] <= cyc + nib_of(k) + 1;
                    m_acc[k]  <= m_acc[k] + 1;
                end
            end else if ((cyc >= m_done[k]) && or_v[k]) begin
                m_busy[k] <= 1'b0;
                m_res[k]  <= m_res[k] + 1;
            end
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int k = 0; k < 3; k++) begin
                check("out_valid", k, 33'(ov_v[k]), 33'(m_busy[k] && (cyc >= m_done[k])));
                check("busy", k, 33'(bz_v[k]), 33'(m_busy[k]));
                check("in_ready", k, 33'(ir_v[k]), 33'(!m_busy[k] && !rst));
                if (m_busy[k] && (cyc >= m_done[k])) check("sum", k, s_v[k], m_sum[k]);
                if (ov_v[k] && or_v[k]) dut_res[k] <= dut_res[k] + 1;
            end
        end
    end

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input bit scramble, input logic [32:0] exp, input string name);
        int lat;
        a16  = a;
        b16  = b;
        ci16 = c;
        iv16 = 1'b1;
        tick();
        iv16 = 1'b0;
        if (scramble) begin
            a16  = 16'hFFFF;
            b16  = 16'hFFFF;
            ci16 = 1'b1;
        end
        lat = 1;
        while (!ov16 && lat < 20) begin
            tick();
            lat++;
        end
        check({name, "_latency"}, 1, 33'(lat), 33'(5));
        check({name, "_sum"}, 1, 33'(s16), exp);
    endtask

    initial begin
        int seen;
        int guard;
        {iv4, or4, ci4, iv16, or16, ci16, iv32, or32, ci32} = '0;
        a4 = '0; b4 = '0; a16 = '0; b16 = '0; a32 = '0; b32 = '0;

        repeat (3) tick();
        check("rst_in_ready", 1, 33'(ir16), 33'(0));
        check("rst_out_valid", 1, 33'(ov16), 33'(0));
        check("rst_busy", 1, 33'(bz16), 33'(0));
        check("rst_sum", 1, 33'(s16), 33'(0));
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 1, 33'(ir16), 33'(1));
        tick();

        or16 = 1'b1;
        op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 33'h10000, "ripple");
        tick();
        op16(16'h1234, 16'h4321, 1'b1, 1'b0, 33'h05556, "mixed");
        tick();
        op16(16'h1234, 16'h4321, 1'b1, 1'b1, 33'h05556, "pins_free");
        tick();

        // Backpressure with a competing request held on the pins.
        or16 = 1'b0;
        op16(16'h1234, 16'h4321, 1'b1, 1'b0, 33'h05556, "bp");
        iv16 = 1'b1;
        a16  = 16'h00AA;
        b16  = 16'h0055;
        ci16 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_sum", 1, 33'(s16), 33'h05556);
            check("bp_out_valid", 1, 33'(ov16), 33'(1));
            check("bp_in_ready", 1, 33'(ir16), 33'(0));
        end
        or16 = 1'b1;
        tick();
        check("bp_release_in_ready", 1, 33'(ir16), 33'(1));
        check("bp_release_out_valid", 1, 33'(ov16), 33'(0));
        op16(16'h00AA, 16'h0055, 1'b0, 1'b0, 33'h000FF, "bp_next");
        tick();

        // Abort mid-RUN.
        iv16 = 1'b1;
        a16  = 16'h0F0F;
        b16  = 16'h0101;
        ci16 = 1'b0;
        tick();
        iv16 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("abort_out_valid", 1, 33'(ov16), 33'(0));
        check("abort_busy", 1, 33'(bz16), 33'(0));
        check("abort_sum", 1, 33'(s16), 33'(0));
        check("abort_in_ready", 1, 33'(ir16), 33'(0));
        rst = 1'b0;
        #1;
        check("abort_release_in_ready", 1, 33'(ir16), 33'(1));
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ov16) seen++;
        end
        check("abort_no_stale", 1, 33'(seen), 33'(0));

        // Random traffic on all three widths with random consumer stalls.
        guard = 0;
        while ((m_acc[0] < 1000 || m_acc[2] < 1000) && guard < 40000) begin
            a4   = 4'($urandom);
            b4   = 4'($urandom);
            ci4  = 1'($urandom);
            a16  = 16'($urandom);
            b16  = 16'($urandom);
            ci16 = 1'($urandom);
            a32  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            b32  = $urandom;
            ci32 = 1'($urandom);
            iv4  = ($urandom_range(0, 3) != 0);
            iv16 = ($urandom_range(0, 3) != 0);
            iv32 = ($urandom_range(0, 3) != 0);
            or4  = ($urandom_range(0, 2) != 0);
            or16 = ($urandom_range(0, 2) != 0);
            or32 = ($urandom_range(0, 2) != 0);
            tick();
            guard++;
        end
        check("random_budget", 0, 33'(m_acc[0] >= 1000 && m_acc[2] >= 1000), 33'(1));

        {iv4, iv16, iv32} = '0;
        {or4, or16, or32} = '1;
        repeat (20) tick();
        for (int k = 0; k < 3; k++) begin
            check("result_count", k, 33'(dut_res[k]), 33'(m_res[k]));
        end
        check("accept_vs_result", 0, 33'(m_res[0]), 33'(m_acc[0]));
        check("accept_vs_result", 2, 33'(m_res[2]), 33'(m_acc[2]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
